alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the 10-bit combinational signed ALU.
- Keeps the same 8-operation encoding and a 4-bit flag vector; adds generic width, two register stages and valid/ready handshaking with backpressure.
- Adds a sticky overflow register and a completed-operation counter.
- Sits between an operand producer and a result consumer, both using valid/ready.

---
 rtl/alu_pipe.sv | 171 +++++++++++++++++
 tb/tb_alu_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with valid/ready handshaking,
// sticky overflow flag and a completed-operation counter.
// Optional build macro: ALU_SATURATE_EN (clamp ADD/SUB results on overflow).
module alu_pipe #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    input  logic [2:0]       i_oper,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flag,
    input  logic             i_ovf_clr,
    output logic             o_ovf_sticky,
    output logic [CNT_W-1:0] o_op_count
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MAX  = 3'd2,
        OP_MIN  = 3'd3,
        OP_AND  = 3'd4,
        OP_ORR  = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

`ifdef ALU_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage 1: captured operands
    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;

    // Stage 2: result and flags
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flag_q, flag_d;

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load, accept, handoff;
    logic [WIDTH:0]   sum_w, dif_w;
    logic             a_lt_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // Handshake: S2 may load when empty or draining; S1 may accept when it can move on
    always_comb begin
        s2_load = !s2_v_q || i_ready;
        o_ready = !s1_v_q || s2_load;
        accept  = i_valid && o_ready;
        handoff = s2_v_q && i_ready;
    end

    // ALU datapath on stage-1 operands; overflow is a sign disagreement of the
    // sign-extended (WIDTH+1)-bit result, equivalent to the operand-sign rules
    always_comb begin
        sum_w   = {s1_a_q[WIDTH-1], s1_a_q} + {s1_b_q[WIDTH-1], s1_b_q};
        dif_w   = {s1_a_q[WIDTH-1], s1_a_q} - {s1_b_q[WIDTH-1], s1_b_q};
        a_lt_b  = $signed(s1_a_q) < $signed(s1_b_q);
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (s1_op_q)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_ovf = sum_w[WIDTH] ^ sum_w[WIDTH-1];
`ifdef ALU_SATURATE_EN
                if (alu_ovf) alu_res = sum_w[WIDTH] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_SUB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_ovf = dif_w[WIDTH] ^ dif_w[WIDTH-1];
`ifdef ALU_SATURATE_EN
                if (alu_ovf) alu_res = dif_w[WIDTH] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_MAX:  alu_res = a_lt_b ? s1_b_q : s1_a_q;
            OP_MIN:  alu_res = ($signed(s1_b_q) < $signed(s1_a_q)) ? s1_b_q : s1_a_q;
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            OP_ORR:  alu_res = s1_a_q | s1_b_q;
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_XNOR: alu_res = ~(s1_a_q ^ s1_b_q);
            default: alu_res = '0;
        endcase
    end

    // Next-state for both stages, sticky flag and handoff counter
    always_comb begin
        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_op_d  = s1_op_q;
        s2_v_d   = s2_v_q;
        res_d    = res_q;
        flag_d   = flag_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (accept) begin
            s1_v_d  = 1'b1;
            s1_a_d  = i_arg0;
            s1_b_d  = i_arg1;
            s1_op_d = op_e'(i_oper);
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        if (s2_load) begin
            s2_v_d = s1_v_q;
            // Result only changes when a real beat moves in, keeping o_result quiet otherwise
            if (s1_v_q) begin
                res_d  = alu_res;
                flag_d = {alu_ovf, alu_res[WIDTH-1], (alu_res == '0), ^alu_res};
            end
        end

        // Set on an overflowing handoff takes priority over clear
        if (handoff && flag_q[3])
            sticky_d = 1'b1;
        else if (i_ovf_clr)
            sticky_d = 1'b0;

        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, handoff};
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= OP_ADD;
            s2_v_q   <= 1'b0;
            res_q    <= '0;
            flag_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
            s2_v_q   <= s2_v_d;
            res_q    <= res_d;
            flag_q   <= flag_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_valid      = s2_v_q;
    assign o_result     = res_q;
    assign o_flag       = flag_q;
    assign o_ovf_sticky = sticky_q;
    assign o_op_count   = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=10, CNT_W=16).
module tb_alu_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [9:0]  i_arg0, i_arg1;
    logic [2:0]  i_oper;
    logic        o_valid;
    logic        i_ready;
    logic [9:0]  o_result;
    logic [3:0]  o_flag;
    logic        i_ovf_clr;
    logic        o_ovf_sticky;
    logic [15:0] o_op_count;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(10), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_arg0(i_arg0), .i_arg1(i_arg1), .i_oper(i_oper), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_flag(o_flag),
        .i_ovf_clr(i_ovf_clr), .o_ovf_sticky(o_ovf_sticky), .o_op_count(o_op_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated beat; leaves the result presented, handoff occurs at the next edge
    task automatic send(input string tag, input logic [9:0] a, input logic [9:0] b,
                        input logic [2:0] op, input logic [9:0] er, input logic [3:0] ef);
        i_arg0 = a; i_arg1 = b; i_oper = op; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk({tag, "_vld"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_res"}, {22'd0, o_result}, {22'd0, er});
        chk({tag, "_flg"}, {28'd0, o_flag}, {28'd0, ef});
    endtask

    logic [9:0] exp_res [8];
    logic [3:0] exp_flg [8];
    logic [9:0] bp_exp  [2];
    int         nrx;

    initial begin
        exp_res = '{10'd80, 10'd48, 10'd64, 10'd16, 10'd0, 10'd80, 10'd80, 10'h3AF};
        exp_flg = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
        bp_exp  = '{10'd1, 10'd2};

        i_rst = 1'b1; i_valid = 1'b0; i_arg0 = '0; i_arg1 = '0; i_oper = '0;
        i_ready = 1'b1; i_ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_vld", {31'd0, o_valid}, 32'd0);
        chk("rst_res", {22'd0, o_result}, 32'd0);
        chk("rst_flg", {28'd0, o_flag}, 32'd0);
        chk("rst_sticky", {31'd0, o_ovf_sticky}, 32'd0);
        chk("rst_cnt", {16'd0, o_op_count}, 32'd0);
        chk("rst_rdy", {31'd0, o_ready}, 32'd1);
        i_rst = 1'b0;
        tick();

        // Back-to-back ops 0..7 on A=64, B=16
        for (int op = 0; op < 8; op++) begin
            i_arg0 = 10'd64; i_arg1 = 10'd16; i_oper = 3'(op); i_valid = 1'b1;
            #1 chk($sformatf("b2b_rdy%0d", op), {31'd0, o_ready}, 32'd1);
            tick();
            if (op > 0) begin
                chk($sformatf("b2b_vld%0d", op - 1), {31'd0, o_valid}, 32'd1);
                chk($sformatf("b2b_res%0d", op - 1), {22'd0, o_result}, {22'd0, exp_res[op-1]});
                chk($sformatf("b2b_flg%0d", op - 1), {28'd0, o_flag}, {28'd0, exp_flg[op-1]});
            end
        end
        i_valid = 1'b0;
        tick();
        chk("b2b_res7", {22'd0, o_result}, {22'd0, exp_res[7]});
        chk("b2b_flg7", {28'd0, o_flag}, {28'd0, exp_flg[7]});
        tick();
        chk("b2b_idle", {31'd0, o_valid}, 32'd0);
        chk("b2b_cnt", {16'd0, o_op_count}, 32'd8);

        // Overflow, sticky set / clear / set-beats-clear
        send("sub_noovf", 10'd200, 10'h39C, 3'd1, 10'd300, 4'b0000);
        tick();
        chk("sticky_none", {31'd0, o_ovf_sticky}, 32'd0);
`ifdef ALU_SATURATE_EN
        send("add_pos_ovf", 10'd511, 10'd511, 3'd0, 10'd511, 4'b1001);
`else
        send("add_pos_ovf", 10'd511, 10'd511, 3'd0, 10'h3FE, 4'b1101);
`endif
        tick();
        chk("sticky_set", {31'd0, o_ovf_sticky}, 32'd1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("sticky_clr", {31'd0, o_ovf_sticky}, 32'd0);
`ifdef ALU_SATURATE_EN
        send("add_neg_ovf", 10'h201, 10'h201, 3'd0, 10'h200, 4'b1101);
`else
        send("add_neg_ovf", 10'h201, 10'h201, 3'd0, 10'd2, 4'b1001);
`endif
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("sticky_setwins", {31'd0, o_ovf_sticky}, 32'd1);
`ifdef ALU_SATURATE_EN
        send("sub_pos_ovf", 10'd511, 10'h201, 3'd1, 10'd511, 4'b1001);
`else
        send("sub_pos_ovf", 10'd511, 10'h201, 3'd1, 10'h3FE, 4'b1101);
`endif
        tick();
`ifdef ALU_SATURATE_EN
        send("sub_neg_ovf", 10'h201, 10'd511, 3'd1, 10'h200, 4'b1101);
`else
        send("sub_neg_ovf", 10'h201, 10'd511, 3'd1, 10'd2, 4'b1001);
`endif
        tick();
        chk("ovf_cnt", {16'd0, o_op_count}, 32'd13);

        // Backpressure: consumer stalls 5 cycles while producer keeps offering
        i_ready = 1'b0; i_valid = 1'b1; i_arg1 = 10'd0; i_oper = 3'd0;
        i_arg0 = 10'd1;
        #1 chk("bp_rdy_a", {31'd0, o_ready}, 32'd1);
        tick();
        i_arg0 = 10'd2;
        #1 chk("bp_rdy_b", {31'd0, o_ready}, 32'd1);
        tick();
        i_arg0 = 10'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_rdy_low%0d", c), {31'd0, o_ready}, 32'd0);
            chk($sformatf("bp_hold%0d", c), {22'd0, o_result}, 32'd1);
            chk($sformatf("bp_vld%0d", c), {31'd0, o_valid}, 32'd1);
            tick();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        nrx = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (o_valid) begin
                if (nrx < 2)
                    chk($sformatf("bp_order%0d", nrx), {22'd0, o_result}, {22'd0, bp_exp[nrx]});
                nrx++;
            end
            tick();
        end
        chk("bp_nrx", nrx, 32'd2);
        chk("bp_cnt", {16'd0, o_op_count}, 32'd15);

        // Reset with two beats in flight
        i_valid = 1'b1; i_arg0 = 10'd7; i_arg1 = 10'd1; i_oper = 3'd0;
        tick();
        i_arg0 = 10'd9;
        tick();
        i_valid = 1'b0; i_rst = 1'b1;
        tick();
        chk("rst2_vld", {31'd0, o_valid}, 32'd0);
        chk("rst2_cnt", {16'd0, o_op_count}, 32'd0);
        chk("rst2_sticky", {31'd0, o_ovf_sticky}, 32'd0);
        chk("rst2_res", {22'd0, o_result}, 32'd0);
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst2_stale%0d", c), {31'd0, o_valid}, 32'd0);
        end
        chk("rst2_cnt_end", {16'd0, o_op_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
